watch_gen2: RTL

- Parametrised next-generation keypad-settable digital watch. Holds HH:MM:SS as six BCD digits and advances once per tick of a clock divider.
- Supports 24h or 12h mode and validates each keyed digit. Keypresses are edge-captured, so one press gives one digit.
- Drives an 8-position multiplexed 7-segment display at a configurable scan rate.
- Top-level user block; sits directly on the board clock, keypad and display pins.

---
 rtl/watch_gen2_pkg.sv | 62 ++++++
 rtl/watch_gen2_if.sv | 15 +
 rtl/watch_gen2_key_capture.sv | 35 +++
 rtl/watch_gen2.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/watch_gen2_pkg.sv
// Shared constants, state type and helpers for the keypad-settable watch.
// Digit order everywhere is h_ten, h_one, m_ten, m_one, s_ten, s_one (index 0..5).
package watch_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [2:0] CUR_H_TEN = 3'd0;
  localparam logic [2:0] CUR_H_ONE = 3'd1;
  localparam logic [2:0] CUR_M_TEN = 3'd2;
  localparam logic [2:0] CUR_M_ONE = 3'd3;
  localparam logic [2:0] CUR_S_TEN = 3'd4;
  localparam logic [2:0] CUR_S_ONE = 3'd5;

  typedef enum logic {SET, RUN} state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // h_ten is the value already stored; it only constrains the h_one entry.
  function automatic logic digit_ok(input logic h24, input logic [2:0] cur,
                                    input logic [3:0] d, input logic [3:0] h_ten);
    logic ok;
    case (cur)
      CUR_H_TEN: ok = h24 ? (d <= 4'd2) : (d <= 4'd1);
      CUR_H_ONE: begin
        if (h24)               ok = (h_ten == 4'd2) ? (d <= 4'd3) : (d <= 4'd9);
        else if (h_ten == 4'd1) ok = (d <= 4'd2);
        else                   ok = (d >= 4'd1) && (d <= 4'd9);
      end
      CUR_M_TEN, CUR_S_TEN: ok = (d <= 4'd5);
      CUR_M_ONE, CUR_S_ONE: ok = (d <= 4'd9);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/watch_gen2_if.sv
// Board-side pins of the watch: keypad/set request in, display and status out.
interface watch_gen2_if;
  logic [9:0] keypad;
  logic       set_key;
  logic [7:0] seg_data;
  logic [7:0] seg_com;
  logic       setting;
  logic       pm;
  logic       sec_tick;

  modport master (output keypad, set_key,
                  input  seg_data, seg_com, setting, pm, sec_tick);
  modport slave  (input  keypad, set_key,
                  output seg_data, seg_com, setting, pm, sec_tick);
endinterface

// File: rtl/watch_gen2_key_capture.sv
// Keypad sampler: one press pulse per idle -> single-key transition.
module key_capture (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    output logic       press,
    output logic [3:0] digit
);
    logic [9:0] kp_q;
    logic       idle_q;
    logic [3:0] nlow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kp_q   <= '1;
            idle_q <= 1'b1;
        end else begin
            kp_q   <= keypad;
            idle_q <= &kp_q;
        end
    end

    always_comb begin
        nlow  = '0;
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (!kp_q[i]) begin
                nlow  = nlow + 4'd1;
                digit = 4'(i);
            end
        end
    end

    assign press = (nlow == 4'd1) && idle_q;
endmodule

// File: rtl/watch_gen2.sv
// Keypad-settable HH:MM:SS watch with 8-position multiplexed 7-segment output.
// Optional macro WATCH_BLINK_EN blinks the cursor digit while setting.
module watch_gen2
    import watch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned SCAN_DIV = 1,
    parameter bit          H24      = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    watch_gen2_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [0:5][3:0] TIME_RST = H24 ? 24'h000000 : 24'h120000;

    state_t          state, state_nxt;
    logic [2:0]      cursor;
    logic [0:5][3:0] dig, dig_inc;
    logic            pm_q, pm_inc;
    logic            set_q, sec_tick_q;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   sdiv_cnt;
    logic [2:0]      pos;
    logic [7:0]      seg_data_q, seg_com_q, data_nxt, com_nxt;
    logic            press, set_rise, tick_wrap, accept;
    logic [3:0]      key_digit;

    key_capture u_key (
        .clk    (clk),
        .rst    (rst),
        .keypad (bus.keypad),
        .press  (press),
        .digit  (key_digit)
    );

    assign set_rise  = bus.set_key & ~set_q;
    assign tick_wrap = (state == RUN) && (tick_cnt == TICK_MAX) && !set_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SET;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (state == SET) begin
            accept = press && !set_rise && digit_ok(H24, cursor, key_digit, dig[0]);
            if (accept && cursor == CUR_S_ONE) state_nxt = RUN;
        end
        if (set_rise) state_nxt = SET;
    end

    // BCD increment with carry s -> m -> h; hour wrap depends on mode.
    always_comb begin
        dig_inc = dig;
        pm_inc  = pm_q;
        if (dig[5] != 4'd9) dig_inc[5] = dig[5] + 4'd1;
        else begin
            dig_inc[5] = 4'd0;
            if (dig[4] != 4'd5) dig_inc[4] = dig[4] + 4'd1;
            else begin
                dig_inc[4] = 4'd0;
                if (dig[3] != 4'd9) dig_inc[3] = dig[3] + 4'd1;
                else begin
                    dig_inc[3] = 4'd0;
                    if (dig[2] != 4'd5) dig_inc[2] = dig[2] + 4'd1;
                    else begin
                        dig_inc[2] = 4'd0;
                        if (H24) begin
                            if (dig[0] == 4'd2 && dig[1] == 4'd3) {dig_inc[0], dig_inc[1]} = 8'h00;
                            else if (dig[1] == 4'd9) {dig_inc[0], dig_inc[1]} = {dig[0] + 4'd1, 4'd0};
                            else dig_inc[1] = dig[1] + 4'd1;
                        end else begin
                            if (dig[0] == 4'd1 && dig[1] == 4'd2) {dig_inc[0], dig_inc[1]} = 8'h01;
                            else if (dig[0] == 4'd1 && dig[1] == 4'd1) begin
                                {dig_inc[0], dig_inc[1]} = 8'h12;
                                pm_inc = ~pm_q;
                            end
                            else if (dig[1] == 4'd9) {dig_inc[0], dig_inc[1]} = 8'h10;
                            else dig_inc[1] = dig[1] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor     <= CUR_H_TEN;
            dig        <= TIME_RST;
            pm_q       <= 1'b0;
            set_q      <= 1'b0;
            sec_tick_q <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            set_q      <= bus.set_key;
            sec_tick_q <= tick_wrap;
            if (set_rise) cursor <= CUR_H_TEN;
            else if (accept) begin
                dig[cursor] <= key_digit;
                cursor      <= (cursor == CUR_S_ONE) ? CUR_H_TEN : cursor + 3'd1;
            end
            if (state == RUN && !set_rise) tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
            else                           tick_cnt <= '0;
            if (tick_wrap) begin
                dig  <= dig_inc;
                pm_q <= pm_inc;
            end
        end
    end

`ifdef WATCH_BLINK_EN
    localparam logic [TW-1:0] BLINK_HALF = TW'(TICK_DIV / 2);
    logic [TW-1:0] blink_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blink_cnt <= '0;
        else      blink_cnt <= (blink_cnt == TICK_MAX) ? '0 : blink_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdiv_cnt <= '0;
            pos      <= '0;
        end else if (sdiv_cnt == SCAN_MAX) begin
            sdiv_cnt <= '0;
            pos      <= pos + 3'd1;
        end else begin
            sdiv_cnt <= sdiv_cnt + 1'b1;
        end
    end

    // dp marks the HH:MM:SS colons in 24h mode, or PM on the last digit in 12h mode.
    always_comb begin
        com_nxt  = 8'hFF;
        data_nxt = SEG_BLANK;
        if (pos <= CUR_S_ONE) begin
            com_nxt[3'd7 - pos] = 1'b0;
            data_nxt = seg_decode(dig[pos]);
`ifdef WATCH_BLINK_EN
            if (state == SET && pos == cursor && blink_cnt >= BLINK_HALF) data_nxt = SEG_BLANK;
`endif
            if (H24) data_nxt[0] = (pos == CUR_H_ONE) || (pos == CUR_M_ONE);
            else     data_nxt[0] = (pos == CUR_S_ONE) && pm_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_com_q  <= 8'hFF;
            seg_data_q <= SEG_BLANK;
        end else begin
            seg_com_q  <= com_nxt;
            seg_data_q <= data_nxt;
        end
    end

    assign bus.seg_data = seg_data_q;
    assign bus.seg_com  = seg_com_q;
    assign bus.setting  = (state == SET);
    assign bus.pm       = H24 ? 1'b0 : pm_q;
    assign bus.sec_tick = sec_tick_q;
endmodule
